// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the machine-mode trap sequencer: FSM states, cause codes,
// CSR addresses and mstatus bit positions, plus the mstatus rewrite helpers.
package trap_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSaveMepc,
    StSaveMcause,
    StSaveMstatus,
    StRestoreMstatus,
    StJump
  } state_e;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_MTI    = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI    = 32'h8000_000B;

  localparam logic [11:0] CSR_ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_ADDR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE  = 12'h342;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MIE_MTIE     = 7;
  localparam int unsigned MIE_MEIE     = 11;

  // Trap entry: stash MIE into MPIE and disable interrupts.
  function automatic logic [31:0] trap_entry_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r               = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE and re-arm MPIE.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r               = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle between execute stage, CSR file and PC/hazard logic for trap_ctrl.
interface trap_ctrl_if;
  logic        ecall;
  logic        ebreak;
  logic        mret;
  logic [31:0] inst_addr;
  logic        irq_timer;
  logic        irq_ext;
  logic        glb_int_en;
  logic [31:0] mie;
  logic [31:0] mstatus;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        hold_req;
  logic        csr_wren;
  logic [11:0] csr_wraddr;
  logic [31:0] csr_wrdata;
  logic        jump_en;
  logic [31:0] jump_addr;

  modport master (
    output ecall, ebreak, mret, inst_addr, irq_timer, irq_ext,
    output glb_int_en, mie, mstatus, mtvec, mepc,
    input  hold_req, csr_wren, csr_wraddr, csr_wrdata, jump_en, jump_addr
  );

  modport slave (
    input  ecall, ebreak, mret, inst_addr, irq_timer, irq_ext,
    input  glb_int_en, mie, mstatus, mtvec, mepc,
    output hold_req, csr_wren, csr_wraddr, csr_wrdata, jump_en, jump_addr
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: stalls the pipeline, writes mepc/mcause/mstatus in order,
// then issues a one-cycle redirect to mtvec (trap) or mepc (mret).
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  trap_ctrl_if.slave   bus
);

  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] mstatus_wr_q, mstatus_wr_d;

  logic        irq_ext_en, irq_timer_en;
  logic        take_trap, take_mret;
  logic [31:0] trap_cause;

  assign irq_ext_en   = bus.irq_ext & bus.mie[MIE_MEIE] & bus.glb_int_en;
  assign irq_timer_en = bus.irq_timer & bus.mie[MIE_MTIE] & bus.glb_int_en;

  always_comb begin
    take_trap  = 1'b0;
    take_mret  = 1'b0;
    trap_cause = '0;
    if (state_q == StIdle) begin
      if (bus.ecall) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_ECALL;
      end else if (bus.ebreak) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_EBREAK;
      end else if (bus.mret) begin
        take_mret  = 1'b1;
      end else if (irq_ext_en) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_MEI;
      end else if (irq_timer_en) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_MTI;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    pc_d         = pc_q;
    target_d     = target_q;
    mstatus_wr_d = mstatus_wr_q;
    unique case (state_q)
      StIdle: begin
        if (take_trap) begin
          state_d = StSaveMepc;
          cause_d = trap_cause;
          pc_d    = bus.inst_addr;
        end else if (take_mret) begin
          state_d      = StRestoreMstatus;
          mstatus_wr_d = mret_mstatus(bus.mstatus);
        end
      end
      StSaveMepc:   state_d = StSaveMcause;
      StSaveMcause: begin
        state_d      = StSaveMstatus;
        mstatus_wr_d = trap_entry_mstatus(bus.mstatus);
      end
      StSaveMstatus: begin
        state_d  = StJump;
        target_d = {bus.mtvec[31:2], 2'b00};
      end
      StRestoreMstatus: begin
        state_d  = StJump;
        target_d = bus.mepc;
      end
      StJump:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cause_q      <= '0;
      pc_q         <= '0;
      target_q     <= '0;
      mstatus_wr_q <= '0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      pc_q         <= pc_d;
      target_q     <= target_d;
      mstatus_wr_q <= mstatus_wr_d;
    end
  end

  // Write/jump outputs decode only registered state, so they drop with reset at once.
  always_comb begin
    bus.csr_wren   = 1'b0;
    bus.csr_wraddr = '0;
    bus.csr_wrdata = '0;
    bus.jump_en    = 1'b0;
    bus.jump_addr  = '0;
    unique case (state_q)
      StSaveMepc: begin
        bus.csr_wren   = 1'b1;
        bus.csr_wraddr = CSR_ADDR_MEPC;
        bus.csr_wrdata = pc_q;
      end
      StSaveMcause: begin
        bus.csr_wren   = 1'b1;
        bus.csr_wraddr = CSR_ADDR_MCAUSE;
        bus.csr_wrdata = cause_q;
      end
      StSaveMstatus, StRestoreMstatus: begin
        bus.csr_wren   = 1'b1;
        bus.csr_wraddr = CSR_ADDR_MSTATUS;
        bus.csr_wrdata = mstatus_wr_q;
      end
      StJump: begin
        bus.jump_en   = 1'b1;
        bus.jump_addr = target_q;
      end
      default: ;
    endcase
  end

  assign bus.hold_req = ((state_q != StIdle) | take_trap | take_mret) & ~rst;

endmodule
